elastic_pipe_stage: RTL
=======================

# elastic_pipe_stage

Parametrised, elastic pipeline-stage register for inter-stage boundaries (IF/ID, ID/EXE, EXE/MEM, MEM/WB). It carries a control bundle and a data bundle from producer to consumer with a valid/ready handshake, a 2-entry skid buffer, synchronous flush, and bubble insertion. Control bits are always zero whenever the stage holds no valid instruction, so a downstream stage never acts on stale control.

## Interface
- `CTRL_W`, default 8: width of the control bundle (status_en, mem_read, mem_write, wb_en, branch, I, …); these bits are zeroed on bubble or flush.
- `DATA_W`, default 128: width of the data bundle (pc, operands, immediates, dest, …); retained, not cleared, on bubble.
- `clk`, in, 1: clock; all state updates on its rising edge.
- `rst`, in, 1: reset, asynchronous, active-high.
- `flush`, in, 1: synchronous flush; empties the stage.
- `in_valid`, in, 1: producer has an instruction.
- `in_ready`, out, 1: stage can accept; registered.
- `in_ctrl`, in, CTRL_W: control bundle in.
- `in_data`, in, DATA_W: data bundle in.
- `out_valid`, out, 1: stage presents a valid instruction; registered.
- `out_ready`, in, 1: consumer accepts (deassert = stall).
- `out_ctrl`, out, CTRL_W: control bundle out; zero when `out_valid`=0.
- `out_data`, out, DATA_W: data bundle out.
- `occupancy`, out, 2: number of held entries, 0–2.

## Operation
- Storage: main slot (drives outputs) and skid slot. States: EMPTY (0 entries), ONE (main valid), FULL (main + skid valid).
- Transfers: input transfer = `in_valid & in_ready`; output transfer = `out_valid & out_ready`.
- Transitions, when no flush:
  - EMPTY: `in_valid` → main←in, go to ONE.
  - ONE: out transfer and in transfer → main←in, stay ONE.
  - ONE: out transfer only → go to EMPTY.
  - ONE: in transfer with `!out_ready` → skid←in, go to FULL.
  - ONE: otherwise hold.
  - FULL: `out_ready` → main←skid, go to ONE.
  - FULL: otherwise hold. No input is accepted in FULL.
- `in_ready` = (next state ≠ FULL), registered. It is 1 in EMPTY and ONE, 0 in FULL.
- Bubble: on entering EMPTY, main ctrl register ← 0. Main data register keeps its last value.
- Flush:
  - Highest priority after `rst`.
  - Next state is EMPTY; both ctrl registers ← 0.
  - Any input offered in the same cycle is dropped. The producer sees `in_ready` as it was, and must not count the beat as accepted when it also sees `flush`.
  - `out_valid` falls the next cycle.
- Reset: state EMPTY, `out_valid`=0, `in_ready`=1, `out_ctrl`=0, `out_data`=0, `occupancy`=0, skid slot zeroed. Reset mid-transfer discards both slots.
- Ordering: strict FIFO; skid contents always leave after main contents.

## Timing
- Latency: 1 cycle from input transfer to `out_valid` (via EMPTY or ONE).
- Throughput: 1 transfer/cycle sustained with `out_ready`=1.
- No combinational path from `out_ready` to `in_ready`, or from `in_*` to `out_*`.
- Stall: `out_ready` low for N cycles with `in_valid` high accepts exactly one extra beat, then `in_ready` drops the following cycle.
- Flush and out transfer in the same cycle: the consumer sees the transfer as completed. The flush clears the remaining state.

## Structure
- Shared package `pipe_pkg`: state encoding `ST_EMPTY`=2'd0, `ST_ONE`=2'd1, `ST_FULL`=2'd2; default `CTRL_W`/`DATA_W` constants per stage boundary.
- One sub-module, `pipe_slot`: a `CTRL_W`+`DATA_W` register with load enable and ctrl clear. It is instantiated twice (main, skid).
- Existing fixed stage registers become instances of this block with `out_ready` tied to 1 until hazard logic drives stalls.

## Test plan
- **Reset/idle:** assert `rst` asynchronously mid-cycle → outputs immediately `out_valid`=0, `out_ctrl`=0, `in_ready`=1, `occupancy`=0.
- **Streaming:** `out_ready`=1, push data 0x10,0x11,0x12 back-to-back with ctrl 8'hA5 → same order at output, each 1 cycle later, `occupancy`=1 throughout, no gaps.
- **Stall/skid:** push 0x20, 0x21, 0x22 with `out_ready`=0 from cycle 1 → 0x20 held, 0x21 in skid, `in_ready`=0, `occupancy`=2, 0x22 not accepted. Release `out_ready` → 0x20, 0x21, 0x22 delivered in order.
- **Flush in FULL:** state FULL, assert `flush` with `in_valid`=1 (data 0x30) → next cycle `out_valid`=0, `out_ctrl`=0, `occupancy`=0, 0x30 never appears.
- **Bubble:** single push ctrl 8'hFF, then `in_valid`=0 with `out_ready`=1 → after the transfer `out_ctrl`=0 and `out_data` unchanged.
- **Width params:** `CTRL_W`=1, `DATA_W`=1 and `CTRL_W`=16, `DATA_W`=200 → streaming and stall scenarios pass unchanged.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for elastic pipeline-stage registers.
package pipe_pkg;

    // Stage occupancy encoding; the value equals the number of held entries.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } pipe_state_t;

    // Generic defaults.
    localparam int unsigned DEF_CTRL_W = 8;
    localparam int unsigned DEF_DATA_W = 128;

    // Per-boundary bundle widths.
    localparam int unsigned IF_ID_CTRL_W   = 1;
    localparam int unsigned IF_ID_DATA_W   = 64;
    localparam int unsigned ID_EXE_CTRL_W  = 8;
    localparam int unsigned ID_EXE_DATA_W  = 128;
    localparam int unsigned EXE_MEM_CTRL_W = 4;
    localparam int unsigned EXE_MEM_DATA_W = 104;
    localparam int unsigned MEM_WB_CTRL_W  = 2;
    localparam int unsigned MEM_WB_DATA_W  = 72;

endpackage

// File: rtl/pipe_slot.sv
// One storage slot: control + data register with load enable and control clear.
module pipe_slot #(
    parameter int unsigned CTRL_W = 8,
    parameter int unsigned DATA_W = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic              i_clr,
    input  logic [CTRL_W-1:0] i_ctrl,
    input  logic [DATA_W-1:0] i_data,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [DATA_W-1:0] o_data
);

    logic [CTRL_W-1:0] r_ctrl;
    logic [DATA_W-1:0] r_data;

    // Control register: clear wins over load so a bubble or flush never carries control.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ctrl <= '0;
        end else if (i_clr) begin
            r_ctrl <= '0;
        end else if (i_load) begin
            r_ctrl <= i_ctrl;
        end
    end

    // Data register: only loads, keeps its value across bubbles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data <= '0;
        end else if (i_load) begin
            r_data <= i_data;
        end
    end

    assign o_ctrl = r_ctrl;
    assign o_data = r_data;

endmodule

// File: rtl/elastic_pipe_stage.sv
// Elastic pipeline-stage register with 2-entry skid buffer, flush and bubble insertion.
module elastic_pipe_stage
    import pipe_pkg::*;
#(
    parameter int unsigned CTRL_W = DEF_CTRL_W,
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    pipe_state_t       r_state;
    pipe_state_t       w_next_state;
    logic              r_out_valid;
    logic              r_in_ready;

    logic              w_in_xfer;
    logic              w_out_xfer;
    logic              w_main_load;
    logic              w_main_clr;
    logic              w_main_from_skid;
    logic              w_skid_load;
    logic              w_skid_clr;

    logic [CTRL_W-1:0] w_main_ctrl_d;
    logic [DATA_W-1:0] w_main_data_d;
    logic [CTRL_W-1:0] w_skid_ctrl;
    logic [DATA_W-1:0] w_skid_data;

    assign w_in_xfer  = in_valid & r_in_ready;
    assign w_out_xfer = r_out_valid & out_ready;

    // Main slot refills either from the input or from the skid slot.
    assign w_main_ctrl_d = w_main_from_skid ? w_skid_ctrl : in_ctrl;
    assign w_main_data_d = w_main_from_skid ? w_skid_data : in_data;

    // Next-state and slot-control decode; flush overrides every handshake.
    always_comb begin
        w_next_state     = r_state;
        w_main_load      = 1'b0;
        w_main_clr       = 1'b0;
        w_main_from_skid = 1'b0;
        w_skid_load      = 1'b0;
        w_skid_clr       = 1'b0;
        if (flush) begin
            w_next_state = ST_EMPTY;
            w_main_clr   = 1'b1;
            w_skid_clr   = 1'b1;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_xfer) begin
                        w_main_load  = 1'b1;
                        w_next_state = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_out_xfer && w_in_xfer) begin
                        w_main_load = 1'b1;
                    end else if (w_out_xfer) begin
                        w_main_clr   = 1'b1;
                        w_next_state = ST_EMPTY;
                    end else if (w_in_xfer) begin
                        w_skid_load  = 1'b1;
                        w_next_state = ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (out_ready) begin
                        w_main_load      = 1'b1;
                        w_main_from_skid = 1'b1;
                        w_next_state     = ST_ONE;
                    end
                end
                default: begin
                    w_main_clr   = 1'b1;
                    w_skid_clr   = 1'b1;
                    w_next_state = ST_EMPTY;
                end
            endcase
        end
    end

    // State and registered handshake outputs, all derived from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            r_state     <= w_next_state;
            r_out_valid <= (w_next_state != ST_EMPTY);
            r_in_ready  <= (w_next_state != ST_FULL);
        end
    end

    pipe_slot #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W)
    ) u_main (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_main_load),
        .i_clr  (w_main_clr),
        .i_ctrl (w_main_ctrl_d),
        .i_data (w_main_data_d),
        .o_ctrl (out_ctrl),
        .o_data (out_data)
    );

    pipe_slot #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W)
    ) u_skid (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_skid_load),
        .i_clr  (w_skid_clr),
        .i_ctrl (in_ctrl),
        .i_data (in_data),
        .o_ctrl (w_skid_ctrl),
        .o_data (w_skid_data)
    );

    assign out_valid = r_out_valid;
    assign in_ready  = r_in_ready;
    assign occupancy = 2'(r_state);

endmodule
